// File: rtl/oram_pkg.sv
// Shared constants and types for the Wishbone-loadable output-decode RAM.
package oram_pkg;

  localparam int CTRL_LOCK   = 0;
  localparam int CTRL_LOADED = 1;

  localparam logic [31:0] ORAM_BASE_ADDR = 32'h3000_0000;

  typedef enum logic {
    WB_IDLE,
    WB_ACK
  } wb_state_t;

endpackage

// File: rtl/oram_rd_port.sv
// One registered ORAM read channel: latency 1, returns DEFAULT_V while not loaded.
module oram_rd_port #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  DEFAULT_V = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              loaded,
  input  logic [DATA_W-1:0] mem_word,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;

  // Data only moves on a request, so clearing loaded never glitches an idle port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= rd_en;
      if (rd_en) begin
        data_reg <= loaded ? mem_word : DEFAULT_V;
      end
    end
  end

  assign rd_data  = data_reg;
  assign rd_valid = valid_reg;

endmodule

// File: rtl/oram_wb_loader.sv
// Wishbone-loadable ORAM: WB slave for load/readback/control plus CHANNELS
// independent registered read ports serving TMS1x00 cores.
module oram_wb_loader
  import oram_pkg::*;
#(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 32,
  parameter int                CHANNELS  = 1,
  parameter logic [31:0]       BASE_ADDR = ORAM_BASE_ADDR,
  parameter logic [DATA_W-1:0] DEFAULT_V = '0
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_adr_i,
  input  logic [31:0]                  wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  input  logic [CHANNELS-1:0]          rd_en,
  input  logic [CHANNELS*ADDR_W-1:0]   rd_addr,
  output logic [CHANNELS*DATA_W-1:0]   rd_data,
  output logic [CHANNELS-1:0]          rd_valid,
  output logic                         loaded,
  output logic                         locked
);

  localparam int          DEPTH   = 2 ** ADDR_W;
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'((DEPTH + 1) * 4);

  logic [DATA_W-1:0] mem [DEPTH];

  wb_state_t   state_reg;
  logic        ack_reg;
  logic [31:0] dat_reg;
  logic        loaded_reg;
  logic        locked_reg;

  logic [31:0]       offset;
  logic [ADDR_W:0]   word;
  logic [ADDR_W-1:0] word_idx;
  logic              in_win;
  logic              hit;
  logic              is_ctrl;
  logic              mem_wr;
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_word;
  logic [31:0]       ctrl_word;
  logic              unused_bits;

  // Decode in 33 bits so a window ending at the top of the address map cannot wrap.
  assign offset   = wbs_adr_i - BASE_ADDR;
  assign word     = offset[ADDR_W+2:2];
  assign word_idx = word[ADDR_W-1:0];
  assign in_win   = ({1'b0, wbs_adr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, wbs_adr_i} < WIN_END);
  assign hit      = wbs_cyc_i && wbs_stb_i && in_win;
  assign is_ctrl  = (word == (ADDR_W+1)'(DEPTH));
  assign mem_wr   = hit && (state_reg == WB_IDLE) && wbs_we_i && !is_ctrl && !locked_reg;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign wr_mask[gi] = wbs_sel_i[gi / 8];
    end
  endgenerate

  assign wr_word = (mem[word_idx] & ~wr_mask) | (wbs_dat_i[DATA_W-1:0] & wr_mask);

  always_comb begin
    ctrl_word              = '0;
    ctrl_word[CTRL_LOCK]   = locked_reg;
    ctrl_word[CTRL_LOADED] = loaded_reg;
  end

  // Array is not reset; a write coinciding with reset assertion is dropped.
  always_ff @(posedge wb_clk_i) begin
    if (mem_wr && !wb_rst_i) begin
      mem[word_idx] <= wr_word;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg  <= WB_IDLE;
      ack_reg    <= 1'b0;
      dat_reg    <= '0;
      loaded_reg <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      case (state_reg)
        WB_IDLE: begin
          ack_reg <= 1'b0;
          if (hit) begin
            state_reg <= WB_ACK;
            ack_reg   <= 1'b1;
            if (!wbs_we_i) begin
              dat_reg <= is_ctrl ? ctrl_word : 32'(mem[word_idx]);
            end else if (is_ctrl && wbs_sel_i[0]) begin
              // lock is sticky: only reset can clear it
              loaded_reg <= wbs_dat_i[CTRL_LOADED];
              locked_reg <= locked_reg | wbs_dat_i[CTRL_LOCK];
            end
          end
        end
        WB_ACK: begin
          ack_reg   <= 1'b0;
          state_reg <= WB_IDLE;
        end
        default: begin
          ack_reg   <= 1'b0;
          state_reg <= WB_IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DATA_W-1:0] ch_word;
      assign ch_word = mem[rd_addr[gi*ADDR_W +: ADDR_W]];

      oram_rd_port #(
        .DATA_W    (DATA_W),
        .DEFAULT_V (DEFAULT_V)
      ) u_port (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .rd_en    (rd_en[gi]),
        .loaded   (loaded_reg),
        .mem_word (ch_word),
        .rd_data  (rd_data[gi*DATA_W +: DATA_W]),
        .rd_valid (rd_valid[gi])
      );
    end
  endgenerate

  assign unused_bits = ^{offset[1:0], offset[31:ADDR_W+3], wbs_dat_i, wbs_sel_i};

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign loaded    = loaded_reg;
  assign locked    = locked_reg;

endmodule

// File: tb/tb_oram_wb_loader.sv
// Scoreboard bench for oram_wb_loader: two read channels plus Wishbone load/control.
module tb_oram_wb_loader;

  localparam int          ADDR_W   = 9;
  localparam int          DATA_W   = 32;
  localparam int          CHANNELS = 2;
  localparam int          DEPTH    = 2 ** ADDR_W;
  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [31:0] CTRL_ADR = BASE + DEPTH * 4;
  localparam logic [31:0] DEF_V    = 32'hA5A5_0F0F;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       cyc = 1'b0;
  logic                       stb = 1'b0;
  logic                       we  = 1'b0;
  logic [3:0]                 sel = 4'h0;
  logic [31:0]                adr = '0;
  logic [31:0]                wdat = '0;
  logic                       ack;
  logic [31:0]                rdat;
  logic [CHANNELS-1:0]        rd_en = '0;
  logic [CHANNELS*ADDR_W-1:0] rd_addr = '0;
  logic [CHANNELS*DATA_W-1:0] rd_data;
  logic [CHANNELS-1:0]        rd_valid;
  logic                       loaded;
  logic                       locked;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] wb_q[$];

  oram_wb_loader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CHANNELS  (CHANNELS),
    .BASE_ADDR (BASE),
    .DEFAULT_V (DEF_V)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .loaded    (loaded),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  // One WB transfer; lat = cycles from strobe to ack, 0 if no ack within budget.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output int lat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0; r = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i; r = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd_drive(input int ch, input logic [ADDR_W-1:0] a, input logic [31:0] exp_v);
    rd_en[ch] = 1'b1;
    rd_addr[ch*ADDR_W +: ADDR_W] = a;
    if (ch == 0) exp_q0.push_back(exp_v);
    else         exp_q1.push_back(exp_v);
  endtask

  // Called #1 after the edge following rd_drive: pop and compare every channel.
  task automatic rd_collect(input string tag);
    logic [31:0] e;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      logic pend;
      pend = (ch == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      tests++;
      if (rd_valid[ch] !== pend) begin
        fails++;
        $display("FAIL %s ch%0d rd_valid: got %b want %b", tag, ch, rd_valid[ch], pend);
      end
      if (pend) begin
        e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        tests++;
        if (rd_data[ch*DATA_W +: DATA_W] !== e) begin
          fails++;
          $display("FAIL %s ch%0d rd_data: got %h want %h", tag, ch, rd_data[ch*DATA_W +: DATA_W], e);
        end
        $display("[TB] %s ch%0d read -> %h", tag, ch, rd_data[ch*DATA_W +: DATA_W]);
      end
    end
    rd_en = '0;
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if ({ack, rdat, rd_data, rd_valid, loaded, locked} !== '0) begin
      fails++;
      $display("FAIL reset_state: got ack=%b dat=%h rd=%h v=%b ld=%b lk=%b want all 0",
               ack, rdat, rd_data, rd_valid, loaded, locked);
    end
    $display("[TB] reset state checked");
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_default_read;
    @(posedge clk); #1;
    rd_drive(0, 9'd5, DEF_V);
    @(posedge clk); #1;
    rd_collect("default_read");
    @(posedge clk); #1;
    tests++;
    if (rd_valid[0] !== 1'b0 || rd_data[31:0] !== DEF_V) begin
      fails++;
      $display("FAIL default_hold: got v=%b d=%h want v=0 d=%h", rd_valid[0], rd_data[31:0], DEF_V);
    end
  endtask

  task automatic test_load;
    logic [31:0] r;
    int lat;
    wb_xfer(1'b1, BASE + 5*4, 32'hDEAD_BEEF, 4'hF, r, lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL load_wr_ack: latency %0d want 1", lat); end
    $display("[TB] WB write word5 = deadbeef, ack latency %0d", lat);
    wb_xfer(1'b1, CTRL_ADR, 32'h2, 4'hF, r, lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL ctrl_wr_ack: latency %0d want 1", lat); end
    tests++;
    if (loaded !== 1'b1 || locked !== 1'b0) begin
      fails++;
      $display("FAIL ctrl_loaded: got ld=%b lk=%b want ld=1 lk=0", loaded, locked);
    end
    $display("[TB] WB write CTRL = 2, ack latency %0d", lat);
    @(posedge clk); #1;
    rd_drive(0, 9'd5, 32'hDEAD_BEEF);
    rd_drive(1, 9'd5, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rd_collect("load_read");
  endtask

  task automatic test_byte_lanes;
    logic [31:0] r;
    int lat;
    wb_xfer(1'b1, BASE + 5*4, 32'h0000_AA00, 4'b0010, r, lat);
    wb_q.push_back(32'hDEAD_AAEF);
    wb_xfer(1'b0, BASE + 5*4, '0, 4'hF, r, lat);
    tests++;
    if (lat !== 1 || r !== wb_q.pop_front()) begin
      fails++;
      $display("FAIL byte_lane_read: got %h lat %0d want deadaaef lat 1", r, lat);
    end
    $display("[TB] WB read word5 -> %h", r);
    wb_q.push_back(32'h2);
    wb_xfer(1'b0, CTRL_ADR, '0, 4'hF, r, lat);
    tests++;
    if (r !== wb_q.pop_front()) begin
      fails++;
      $display("FAIL ctrl_read: got %h want 00000002", r);
    end
    $display("[TB] WB read CTRL -> %h", r);
  endtask

  task automatic test_collision;
    logic [31:0] r;
    int lat;
    wb_xfer(1'b1, BASE + 7*4, 32'h5555_6666, 4'hF, r, lat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 7*4; wdat = 32'h0000_1234; sel = 4'hF;
    rd_drive(0, 9'd7, 32'h5555_6666);
    @(posedge clk); #1;
    tests++;
    if (ack !== 1'b1) begin fails++; $display("FAIL collision_ack: got %b want 1", ack); end
    rd_collect("collision_old");
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rd_drive(1, 9'd7, 32'h0000_1234);
    @(posedge clk); #1;
    rd_collect("collision_new");
  endtask

  task automatic test_back_to_back;
    logic exp_ack [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 7*4; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++;
      if (ack !== exp_ack[i]) begin
        fails++;
        $display("FAIL b2b_ack[%0d]: got %b want %b", i, ack, exp_ack[i]);
      end
      $display("[TB] back-to-back cycle %0d ack=%b", i, ack);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lock;
    logic [31:0] r;
    int lat;
    wb_xfer(1'b1, CTRL_ADR, 32'h3, 4'hF, r, lat);
    wb_xfer(1'b1, CTRL_ADR, 32'h2, 4'hF, r, lat);
    tests++;
    if (locked !== 1'b1 || loaded !== 1'b1) begin
      fails++;
      $display("FAIL lock_sticky: got lk=%b ld=%b want lk=1 ld=1", locked, loaded);
    end
    wb_xfer(1'b1, BASE + 5*4, 32'h0, 4'hF, r, lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL locked_wr_ack: latency %0d want 1", lat); end
    wb_q.push_back(32'hDEAD_AAEF);
    wb_xfer(1'b0, BASE + 5*4, '0, 4'hF, r, lat);
    tests++;
    if (r !== wb_q.pop_front()) begin
      fails++;
      $display("FAIL locked_word: got %h want deadaaef", r);
    end
    $display("[TB] locked write ignored, word5 -> %h", r);
  endtask

  task automatic test_unload;
    logic [31:0] r;
    int lat;
    wb_xfer(1'b1, CTRL_ADR, 32'h0, 4'hF, r, lat);
    tests++;
    if (loaded !== 1'b0 || locked !== 1'b1) begin
      fails++;
      $display("FAIL unload_ctrl: got ld=%b lk=%b want ld=0 lk=1", loaded, locked);
    end
    @(posedge clk); #1;
    tests++;
    if (rd_data[63:32] !== 32'h0000_1234) begin
      fails++;
      $display("FAIL unload_hold: got %h want 00001234", rd_data[63:32]);
    end
    rd_drive(1, 9'd7, DEF_V);
    @(posedge clk); #1;
    rd_collect("unload_read");
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int lat;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 9*4; wdat = 32'h9999; sel = 4'hF;
    @(posedge clk); #1;
    tests++;
    if (ack !== 1'b1) begin fails++; $display("FAIL mid_pre_ack: got %b want 1", ack); end
    rst = 1'b1;
    #1;
    tests++;
    if (ack !== 1'b0 || loaded !== 1'b0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got ack=%b ld=%b lk=%b want 0 0 0", ack, loaded, locked);
    end
    $display("[TB] reset during ack: ack=%b loaded=%b locked=%b", ack, loaded, locked);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    wb_xfer(1'b0, BASE + (DEPTH + 1) * 4, '0, 4'hF, r, lat);
    tests++;
    if (lat !== 0) begin fails++; $display("FAIL out_of_window: ack after %0d want none", lat); end
    wb_xfer(1'b0, BASE - 4, '0, 4'hF, r, lat);
    tests++;
    if (lat !== 0) begin fails++; $display("FAIL below_window: ack after %0d want none", lat); end
    $display("[TB] out-of-window accesses not acked");
  endtask

  initial begin
    test_reset();
    test_default_read();
    test_load();
    test_byte_lanes();
    test_collision();
    test_back_to_back();
    test_lock();
    test_unload();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
